// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive path.
//   uart_byte_t             one data byte
//   uart_rx_entry_t         buffered receive entry {perr, data}
//   UART_RX_FIFO_DEPTH_DEF  default receive buffer depth
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    typedef struct packed {
        logic       perr;
        uart_byte_t data;
    } uart_rx_entry_t;

    localparam int unsigned UART_RX_FIFO_DEPTH_DEF = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x WIDTH register array, one write port, combinational read.
// Contents clear to zero on asynchronous reset.
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  storage[rd_addr], combinational
module uart_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte buffer between the UART receiver and its consumer.
// Captures each received byte (plus parity-error flag) into a circular buffer and
// presents the head first-word-fall-through on a valid/ready interface.
// Build option: define UART_RX_FIFO_PERR_EN to store the parity-error flag with
// each byte (9-bit entries) and accept parity-error-only beats; otherwise entries
// are 8 bits, parity-error-only beats are ignored and m_perr is tied low.
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   rx_data      in   byte from receiver, valid with rx_valid or rx_perr
//   rx_valid     in   pulse: good byte on rx_data
//   rx_perr      in   pulse: parity error on rx_data byte
//   rx_rd_ready  out  buffer can accept one more byte (one-slot look-ahead)
//   m_data       out  head entry byte
//   m_perr       out  head entry parity-error flag
//   m_valid      out  buffer not empty
//   m_ready      in   consumer pops head when m_valid & m_ready
//   count        out  occupancy 0..DEPTH
//   overflow     out  sticky: a byte arrived while full
//   ovf_clr      in   synchronous clear of overflow
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          rx_perr,
    output logic          rx_rd_ready,
    output logic [7:0]    m_data,
    output logic          m_perr,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr
);

`ifdef UART_RX_FIFO_PERR_EN
    localparam int unsigned EW = $bits(uart_rx_entry_t);
`else
    localparam int unsigned EW = $bits(uart_byte_t);
`endif

    localparam logic [AW:0]   DepthCnt  = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] DepthWide = (AW+2)'(DEPTH);

    logic          beat;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [AW+1:0] look_ahead;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    // Entry packing and the notion of an arriving byte depend on the build option.
`ifdef UART_RX_FIFO_PERR_EN
    uart_rx_entry_t in_entry;
    uart_rx_entry_t head_entry;

    assign beat = rx_valid | rx_perr;

    always_comb begin
        in_entry      = '0;
        in_entry.perr = rx_perr;
        in_entry.data = rx_data;
        wr_entry      = in_entry;
        head_entry    = rd_entry;
        m_data        = head_entry.data;
        m_perr        = head_entry.perr;
    end
`else
    logic unused_rx_perr;

    assign unused_rx_perr = rx_perr;
    assign beat           = rx_valid;

    always_comb begin
        wr_entry = rx_data;
        m_data   = rd_entry;
        m_perr   = 1'b0;
    end
`endif

    // Push is judged on the registered count: a same-cycle pop at full does not
    // make room for the byte arriving in that cycle.
    assign full    = (count_q == DepthCnt);
    assign push    = beat & ~full;
    assign drop    = beat & full;
    assign m_valid = (count_q != '0);
    assign pop     = m_valid & m_ready;

    // Reserve the slot for a byte landing this cycle; the receiver acts on ready
    // one cycle later and bytes are at least a frame apart.
    assign look_ahead  = {1'b0, count_q} + (AW+2)'(beat);
    assign rx_rd_ready = (look_ahead < DepthWide);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        // Set dominates clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_entry)
    );

    assign count    = count_q;
    assign overflow = overflow_q;

    // Occupancy never exceeds capacity.
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= DepthCnt);

    // Pointer distance always agrees with the tracked occupancy.
    a_ptr_count: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_ptr_q - rd_ptr_q) == count_q[AW-1:0]);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo (DEPTH = 16).
// Table-driven single-cycle vectors plus hand-written multi-cycle sequences; popped
// entries are checked against a scoreboard queue filled when bytes are driven.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_PERR_EN
    localparam int PE = 1;
`else
    localparam int PE = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_perr;
    logic       rx_rd_ready;
    logic [7:0] m_data;
    logic       m_perr;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr;

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_perr     (rx_perr),
        .rx_rd_ready (rx_rd_ready),
        .m_data      (m_data),
        .m_perr      (m_perr),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .count       (count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Bench-side reference state.
    int         mcnt = 0;
    logic       movf = 1'b0;
    logic [8:0] sb_q[$];

    typedef struct {
        logic       v;
        logic       p;
        logic [7:0] d;
        logic       r;
        logic       c;
        int         cnt;
        logic       vld;
        logic       ovf;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs and any pop before
    // the edge, then check registered state after it. Entered ~1 unit past a posedge.
    task automatic cycle(input logic v, input logic p, input logic [7:0] d,
                         input logic r, input logic c);
        logic       beat;
        logic       do_push;
        logic       do_pop;
        logic       do_drop;
        logic [8:0] exp_e;
        rx_valid = v;
        rx_perr  = p;
        rx_data  = d;
        m_ready  = r;
        ovf_clr  = c;
        #2;
        beat    = (PE != 0) ? (v | p) : v;
        do_push = beat && (mcnt != DEPTH);
        do_drop = beat && (mcnt == DEPTH);
        do_pop  = (mcnt != 0) && r;
        check("rx_rd_ready", rx_rd_ready, ((mcnt + int'(beat)) < DEPTH) ? 1 : 0);
        check("m_valid_pre", m_valid, (mcnt != 0) ? 1 : 0);
        if (do_pop) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_empty_sb: got m_data 0x%0h expected no entry", m_data);
            end else begin
                exp_e = sb_q.pop_front();
                check("m_data", m_data, exp_e[7:0]);
                check("m_perr", m_perr, exp_e[8]);
            end
        end
        if (do_push) begin
            sb_q.push_back({((PE != 0) ? p : 1'b0), d});
        end
        @(posedge clk);
        #1;
        mcnt = mcnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        if (do_drop) movf = 1'b1;
        else if (c)  movf = 1'b0;
        rx_valid = 1'b0;
        rx_perr  = 1'b0;
        rx_data  = 8'h00;
        m_ready  = 1'b0;
        ovf_clr  = 1'b0;
        check("count", count, mcnt);
        check("overflow", overflow, movf);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && mcnt != 0; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        check(name, count, 0);
        check({name, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_perr  = 1'b0;
        rx_data  = 8'h00;
        m_ready  = 1'b0;
        ovf_clr  = 1'b0;

        // Single-cycle vectors; expected state after the edge.
        tbl[0]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1,      1'b1,       1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0,      1'b0,       1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1,      1'b1,       1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 2,      1'b1,       1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 2,      1'b1,       1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 2 + PE, 1'b1,       1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1 + PE, 1'b1,       1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, PE,     (PE != 0),  1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0,      1'b0,       1'b0};
        tbl[9]  = '{1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1,      1'b1,       1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0,      1'b0,       1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0,      1'b0,       1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rx_rd_ready", rx_rd_ready, 1);
        check("rst_m_data", m_data, 8'h00);
        check("rst_m_perr", m_perr, 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].v, tbl[i].p, tbl[i].d, tbl[i].r, tbl[i].c);
            check($sformatf("vec%0d_count", i), count, tbl[i].cnt);
            check($sformatf("vec%0d_m_valid", i), m_valid, tbl[i].vld);
            check($sformatf("vec%0d_overflow", i), overflow, tbl[i].ovf);
            if (i == 0) begin
                check("vec0_m_data", m_data, 8'hA5);
                check("vec0_m_perr", m_perr, 0);
            end
        end

        // Fill to capacity; ready drops in the cycle the 16th byte lands.
        for (int i = 0; i < DEPTH; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            #1;
            check($sformatf("fill%0d_rdy", i), rx_rd_ready, (i != DEPTH - 1) ? 1 : 0);
            cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        end
        check("full_count", count, 16);
        check("full_rdy", rx_rd_ready, 0);

        // Overrun handling.
        cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 16);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", overflow, 0);
        cycle(1'b1, 1'b0, 8'h78, 1'b0, 1'b1);
        check("ovf_set_wins", overflow, 1);
        // Pop at full frees a slot but the same-cycle byte is still rejected.
        cycle(1'b1, 1'b0, 8'h79, 1'b1, 1'b0);
        check("full_pop_push_count", count, 15);
        check("full_pop_push_ovf", overflow, 1);
        drain("fill_drain");
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Steady push+pop at count 5, running the pointers through several wraps.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 22; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h3C + i), 1'b1, 1'b0);
            check($sformatf("pp%0d_count", i), count, 5);
        end
        drain("pp_drain");

        // Asynchronous reset mid-stream discards contents at once.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(8'hE0 + i), 1'b0, 1'b0);
        check("pre_rst_count", count, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_m_valid", m_valid, 0);
        check("arst_rdy", rx_rd_ready, 1);
        mcnt = 0;
        movf = 1'b0;
        sb_q.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        check("post_rst_head", m_data, 8'h5A);
        drain("post_rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
